// File: rtl/mat_accum_if.sv
// Beat/result handshake bundle between mult_array, mat_accum and the readback logic.
interface mat_accum_if #(
    parameter int unsigned N = 6,
    parameter int unsigned W = 27
);
    logic                      in_valid;
    logic [N*N-1:0][W-1:0]     products;
    logic                      in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [N*N-1:0][W-1:0]     result;
    logic                      ovf;

    // Producer of k-slices and consumer of results.
    modport master (
        output in_valid, products, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, products, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/mat_accum.sv
// Outer-product accumulator: sums N k-slices of N*N products element-wise with
// saturating signed arithmetic and presents the finished matrix over valid/ready.
module mat_accum #(
    parameter int unsigned N = 6,
    parameter int unsigned W = 27
) (
    input logic         clk,
    input logic         reset_n,
    input logic         en,
    input logic         clear,
    mat_accum_if.slave  bus
);
    localparam int unsigned NE = N * N;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast  = KW'(N - 1);
    localparam logic [W-1:0]  SatMax = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  SatMin = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e                state_q;
    logic [KW-1:0]         k_q;
    logic [NE-1:0][W-1:0]  acc_q;
    logic [NE-1:0][W-1:0]  result_q;
    logic                  out_valid_q;
    logic                  ovf_acc_q;
    logic                  ovf_q;

    logic [NE-1:0][W-1:0]  sum_sat;
    logic                  any_sat;

    // Element-wise acc + products at W+1 bits, clamped to the W-bit signed range.
    always_comb begin : sat_add
        logic [W:0] s;
        s       = '0;
        sum_sat = '0;
        any_sat = 1'b0;
        for (int e = 0; e < NE; e++) begin
            s = {acc_q[e][W-1], acc_q[e]} + {bus.products[e][W-1], bus.products[e]};
            // The two top bits differ only when the sum left the W-bit range.
            if (s[W] != s[W-1]) begin
                sum_sat[e] = s[W] ? SatMin : SatMax;
                any_sat    = 1'b1;
            end else begin
                sum_sat[e] = s[W-1:0];
            end
        end
    end

    assign bus.in_ready  = en && (state_q != StDone);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;

    // Beat sequencing, accumulation and result presentation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            ovf_acc_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clear) begin
            state_q     <= StIdle;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        // First slice loads directly; nothing to add to.
                        acc_q     <= bus.products;
                        ovf_acc_q <= 1'b0;
                        k_q       <= KW'(1);
                        if (N == 1) begin
                            state_q     <= StDone;
                            result_q    <= bus.products;
                            out_valid_q <= 1'b1;
                            ovf_q       <= 1'b0;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (bus.in_valid) begin
                        acc_q     <= sum_sat;
                        ovf_acc_q <= ovf_acc_q | any_sat;
                        k_q       <= k_q + KW'(1);
                        if (k_q == KLast) begin
                            state_q     <= StDone;
                            result_q    <= sum_sat;
                            out_valid_q <= 1'b1;
                            ovf_q       <= ovf_acc_q | any_sat;
                        end
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        k_q         <= '0;
                        out_valid_q <= 1'b0;
                        ovf_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mat_accum.sv
// Self-checking bench for mat_accum: randomized slices against a saturating-sum model.
module tb_mat_accum;
    localparam int unsigned N  = 6;
    localparam int unsigned W  = 27;
    localparam int unsigned NE = N * N;
    typedef logic [NE-1:0][W-1:0] mat_t;

    localparam longint MaxV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MinV = -(longint'(1) <<< (W - 1));

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic clear;
    int   n_tests = 0;
    int   n_fail  = 0;

    mat_accum_if #(.N(N), .W(W)) bus ();

    mat_accum #(.N(N), .W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clear   (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: real-valued sums clamped into the signed W-bit range.
    longint m_acc [NE];
    bit     m_ovf;
    int     m_k;
    mat_t   exp_res;
    bit     exp_ovf;

    function automatic void model_beat(input mat_t p);
        longint v, s;
        if (m_k == 0) m_ovf = 1'b0;
        for (int e = 0; e < NE; e++) begin
            v = longint'($signed(p[e]));
            if (m_k == 0) begin
                m_acc[e] = v;
            end else begin
                s = m_acc[e] + v;
                if (s > MaxV) begin s = MaxV; m_ovf = 1'b1; end
                if (s < MinV) begin s = MinV; m_ovf = 1'b1; end
                m_acc[e] = s;
            end
        end
        m_k++;
        if (m_k == N) begin
            m_k = 0;
            for (int e = 0; e < NE; e++) exp_res[e] = W'(m_acc[e]);
            exp_ovf = m_ovf;
        end
    endfunction

    function automatic mat_t rand_mat(input int mode);
        mat_t m;
        int   v;
        for (int e = 0; e < NE; e++) begin
            if (mode == 0) begin
                v    = int'($urandom_range(0, 1 << 23)) - (1 << 22);
                m[e] = W'(v);
            end else begin
                m[e] = W'($urandom);
            end
        end
        return m;
    endfunction

    function automatic mat_t fill(input logic [W-1:0] v);
        mat_t m;
        for (int e = 0; e < NE; e++) m[e] = v;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input mat_t p);
        bus.in_valid = 1'b1;
        bus.products = p;
        tick();
        model_beat(p);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.products = '0; bus.out_ready = 1'b1;
        m_k = 0;
        #12;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_en0: got %b want 0", bus.in_ready); end
        en = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_en1: got %b want 1", bus.in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        for (int b = 0; b < N; b++) begin
            send_beat(fill(27'h100));
            if (b == N - 2) begin
                n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ident_early_valid: got %b want 0", bus.out_valid); end
            end
        end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ident_valid: got %b want 1", bus.out_valid); end
        n_tests++; if (bus.result !== fill(27'h600)) begin n_fail++; $display("FAIL ident_result: got %h want %h", bus.result, fill(27'h600)); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ident_ovf: got %b want 0", bus.ovf); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ident_in_ready: got %b want 0", bus.in_ready); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ident_valid_one_cycle: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ident_ready_after: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_pos_sat();
        mat_t p, r;
        p    = fill(W'(28'hFFFFF00));
        p[0] = 27'h3000000;
        for (int b = 0; b < N; b++) send_beat(p);
        r = bus.result;
        n_tests++; if (r[0] !== 27'h3FFFFFF) begin n_fail++; $display("FAIL possat_elem0: got %h want 3ffffff", r[0]); end
        n_tests++; if (r[1] !== 27'h7FFFA00) begin n_fail++; $display("FAIL possat_elem1: got %h want 7fffa00", r[1]); end
        n_tests++; if (r !== exp_res) begin n_fail++; $display("FAIL possat_result: got %h want %h", r, exp_res); end
        n_tests++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL possat_ovf: got %b want 1", bus.ovf); end
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int b = 0; b < N; b++) send_beat(rand_mat(0));
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", bus.out_valid); end
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.products = rand_mat(1);
            #1;
            n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
            tick();
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", bus.out_valid); end
            n_tests++; if (bus.result !== exp_res) begin n_fail++; $display("FAIL bp_hold_result: got %h want %h", bus.result, exp_res); end
            n_tests++; if (bus.ovf !== exp_ovf) begin n_fail++; $display("FAIL bp_hold_ovf: got %b want %b", bus.ovf, exp_ovf); end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", bus.out_valid); end
        for (int b = 0; b < N; b++) send_beat(rand_mat(0));
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", bus.out_valid); end
        n_tests++; if (bus.result !== exp_res) begin n_fail++; $display("FAIL bp_next_result: got %h want %h", bus.result, exp_res); end
        tick();
    endtask

    task automatic test_neg_sat();
        for (int b = 0; b < N; b++) send_beat(fill(27'h4000000));
        n_tests++; if (bus.result !== fill(27'h4000000)) begin n_fail++; $display("FAIL negsat_result: got %h want %h", bus.result, fill(27'h4000000)); end
        n_tests++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL negsat_ovf: got %b want 1", bus.ovf); end
        tick();
    endtask

    task automatic test_en_stall();
        for (int b = 0; b < 2; b++) send_beat(rand_mat(0));
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.products = rand_mat(1);
            #1;
            n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
            tick();
        end
        en = 1'b1;
        for (int b = 2; b < N; b++) begin
            send_beat(rand_mat(0));
            if (b == N - 2) begin
                n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_count: got %b want 0", bus.out_valid); end
            end
        end
        n_tests++; if (bus.result !== exp_res) begin n_fail++; $display("FAIL stall_result: got %h want %h", bus.result, exp_res); end
        n_tests++; if (bus.ovf !== exp_ovf) begin n_fail++; $display("FAIL stall_ovf: got %b want %b", bus.ovf, exp_ovf); end
        en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_done_hold: got %b want 1", bus.out_valid); end
        end
        en = 1'b1;
        tick();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_handoff: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_gaps();
        for (int b = 0; b < N; b++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                bus.products = rand_mat(1);
                tick();
            end
            send_beat(rand_mat(0));
        end
        n_tests++; if (bus.result !== exp_res) begin n_fail++; $display("FAIL gaps_result: got %h want %h", bus.result, exp_res); end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid: got %b want 1", bus.out_valid); end
        tick();
    endtask

    task automatic test_clear();
        for (int b = 0; b < 4; b++) send_beat(fill(27'h100));
        // Clear wins even with en low.
        en = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; en = 1'b1;
        m_k = 0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %b want 0", bus.out_valid); end
        for (int b = 0; b < N; b++) send_beat(fill(27'h100));
        n_tests++; if (bus.result !== fill(27'h600)) begin n_fail++; $display("FAIL clear_result: got %h want %h", bus.result, fill(27'h600)); end
        tick();
        bus.out_ready = 1'b0;
        for (int b = 0; b < N; b++) send_beat(fill(27'h4000000));
        n_tests++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL clear_done_ovf_pre: got %b want 1", bus.ovf); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_done_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL clear_done_ovf: got %b want 0", bus.ovf); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        for (int b = 0; b < 3; b++) send_beat(rand_mat(0));
        #3;
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_accum_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.result !== '0) begin n_fail++; $display("FAIL areset_accum_result: got %h want 0", bus.result); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL areset_accum_ovf: got %b want 0", bus.ovf); end
        @(negedge clk);
        reset_n = 1'b1;
        m_k = 0;
        tick();
        bus.out_ready = 1'b0;
        for (int b = 0; b < N; b++) send_beat(fill(27'h4000000));
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_done_pre: got %b want 1", bus.out_valid); end
        #3;
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_done_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.result !== '0) begin n_fail++; $display("FAIL areset_done_result: got %h want 0", bus.result); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL areset_done_ovf: got %b want 0", bus.ovf); end
        @(negedge clk);
        reset_n = 1'b1;
        m_k = 0;
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_ovf_clear();
        for (int b = 0; b < N; b++) send_beat(fill(27'h4000000));
        n_tests++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovfclr_first: got %b want 1", bus.ovf); end
        tick();
        for (int b = 0; b < N; b++) send_beat(rand_mat(0));
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovfclr_second: got %b want 0", bus.ovf); end
        n_tests++; if (bus.result !== exp_res) begin n_fail++; $display("FAIL ovfclr_result: got %h want %h", bus.result, exp_res); end
        tick();
    endtask

    task automatic test_back_to_back();
        mat_t p;
        for (int m = 0; m < 4; m++) begin
            for (int b = 0; b < N; b++) begin
                p = rand_mat(m % 2);
                bus.in_valid = 1'b1;
                bus.products = p;
                tick();
                model_beat(p);
            end
            // Handoff cycle: in_valid stays high with junk that must be ignored.
            bus.products = rand_mat(1);
            #1;
            n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 0", bus.in_ready); end
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", bus.out_valid); end
            n_tests++; if (bus.result !== exp_res) begin n_fail++; $display("FAIL b2b_result: got %h want %h", bus.result, exp_res); end
            n_tests++; if (bus.ovf !== exp_ovf) begin n_fail++; $display("FAIL b2b_ovf: got %b want %b", bus.ovf, exp_ovf); end
            tick();
            n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b want 0", bus.out_valid); end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_pos_sat();
        test_backpressure();
        test_neg_sat();
        test_en_stall();
        test_gaps();
        test_clear();
        test_async_reset();
        test_ovf_clear();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
